// File: rtl/sobel_cfg_ctrl_if.sv
// Register access bus for the Sobel configuration controller.
// The host drives strobes, address and write data; the controller returns registered read data.
interface sobel_cfg_ctrl_if;
    logic        reg_wr;
    logic        reg_rd;
    logic [2:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rvalid;

    modport master (
        output reg_wr, reg_rd, reg_addr, reg_wdata,
        input  reg_rdata, reg_rvalid
    );

    modport slave (
        input  reg_wr, reg_rd, reg_addr, reg_wdata,
        output reg_rdata, reg_rvalid
    );
endinterface

// File: rtl/sobel_cfg_ctrl.sv
// Sobel pipeline configuration shadowing with vsync-aligned commit, plus resolution
// measurement, frame counting and lock detection behind a small register port.
module sobel_cfg_ctrl #(
    parameter logic [7:0]  THRESH_RST = 8'd64,
    parameter logic [2:0]  MODE_RST   = 3'd0,
    parameter int unsigned CNT_W      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    sobel_cfg_ctrl_if.slave      bus,
    input  logic                 dv_i,
    input  logic                 hs_i,
    input  logic                 vs_i,
    output logic                 cfg_bypass,
    output logic [2:0]           cfg_mode,
    output logic [7:0]           cfg_thresh,
    output logic [15:0]          frame_cnt,
    output logic                 locked
);

    typedef enum logic {StIdle, StPending} commit_e;
    typedef enum logic [1:0] {StUnlocked, StCheck, StLocked} lock_e;

    commit_e commit_q, commit_d;
    lock_e   lock_q, lock_d;

    logic             vs_q, dv_q, first_vs_q, first_vs_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, h_line_q, h_line_d, v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0] h_active_q, h_active_d, v_active_q, v_active_d;
    logic [15:0]      frame_q, frame_d;
    logic             sh_bypass_q, sh_bypass_d, cfg_bypass_q, cfg_bypass_d;
    logic [2:0]       sh_mode_q, sh_mode_d, cfg_mode_q, cfg_mode_d;
    logic [7:0]       sh_thresh_q, sh_thresh_d, cfg_thresh_q, cfg_thresh_d;
    logic [31:0]      rdata_q, rdata_d, rd_mux;
    logic             rvalid_q;

    logic vs_rise, dv_fall, meas_upd, wr_ctrl, wr_thresh, commit_req;
    logic apply, pending, meas_nonzero, meas_same;
    logic unused_bits;

    assign vs_rise    = vs_i & ~vs_q;
    assign dv_fall    = dv_q & ~dv_i;
    assign meas_upd   = vs_rise & first_vs_q;
    assign wr_ctrl    = bus.reg_wr && (bus.reg_addr == 3'd0);
    assign wr_thresh  = bus.reg_wr && (bus.reg_addr == 3'd1);
    assign commit_req = wr_ctrl & bus.reg_wdata[8];
    assign unused_bits = ^{hs_i, bus.reg_wdata[31:9], bus.reg_wdata[7:4]};

    assign meas_nonzero = (h_line_q != '0) && (v_cnt_q != '0);
    assign meas_same    = (h_line_q == h_active_q) && (v_cnt_q == v_active_q);

    // Commit FSM
    always_ff @(posedge clk) begin
        if (rst) commit_q <= StIdle;
        else     commit_q <= commit_d;
    end

    always_comb begin
        commit_d = commit_q;
        unique case (commit_q)
            StIdle:    if (commit_req) commit_d = StPending;
            StPending: if (vs_rise)    commit_d = StIdle;
            default:   commit_d = StIdle;
        endcase
    end

    always_comb begin
        pending = (commit_q == StPending);
        apply   = pending & vs_rise;
    end

    // Lock FSM; a zero-sized measurement never counts as a stable match
    always_ff @(posedge clk) begin
        if (rst) lock_q <= StUnlocked;
        else     lock_q <= lock_d;
    end

    always_comb begin
        lock_d = lock_q;
        if (meas_upd) begin
            unique case (lock_q)
                StUnlocked: if (meas_nonzero) lock_d = StCheck;
                StCheck:    if (meas_nonzero && meas_same) lock_d = StLocked;
                StLocked:   if (!meas_nonzero || !meas_same) lock_d = StCheck;
                default:    lock_d = StUnlocked;
            endcase
        end
    end

    always_comb begin
        locked = (lock_q == StLocked);
    end

    // Measurement, shadows and active configuration
    always_comb begin
        h_cnt_d      = h_cnt_q;
        h_line_d     = h_line_q;
        v_cnt_d      = v_cnt_q;
        h_active_d   = h_active_q;
        v_active_d   = v_active_q;
        frame_d      = frame_q;
        first_vs_d   = first_vs_q;
        sh_bypass_d  = sh_bypass_q;
        sh_mode_d    = sh_mode_q;
        sh_thresh_d  = sh_thresh_q;
        cfg_bypass_d = cfg_bypass_q;
        cfg_mode_d   = cfg_mode_q;
        cfg_thresh_d = cfg_thresh_q;

        if (dv_i && (h_cnt_q != '1)) h_cnt_d = h_cnt_q + CNT_W'(1);
        if (dv_fall) begin
            h_line_d = h_cnt_q;
            h_cnt_d  = '0;
            if (v_cnt_q != '1) v_cnt_d = v_cnt_q + CNT_W'(1);
        end
        if (vs_rise) begin
            frame_d = frame_q + 16'd1;
            if (first_vs_q) begin
                h_active_d = h_line_q;
                v_active_d = v_cnt_q;
            end
            first_vs_d = 1'b1;
            v_cnt_d    = '0;
        end

        if (wr_ctrl) begin
            sh_bypass_d = bus.reg_wdata[0];
            sh_mode_d   = bus.reg_wdata[3:1];
        end
        if (wr_thresh) sh_thresh_d = bus.reg_wdata[7:0];

        if (apply) begin
            cfg_bypass_d = sh_bypass_q;
            cfg_mode_d   = sh_mode_q;
            cfg_thresh_d = sh_thresh_q;
        end
    end

    // Read mux uses pre-write state so a same-cycle write is not visible
    always_comb begin
        rd_mux = '0;
        unique case (bus.reg_addr)
            3'd0: begin
                rd_mux[0]   = sh_bypass_q;
                rd_mux[3:1] = sh_mode_q;
            end
            3'd1: rd_mux[7:0] = sh_thresh_q;
            3'd2: rd_mux[1:0] = {pending, locked};
            3'd3: rd_mux[15:0] = frame_q;
            3'd4: begin
                rd_mux[16 +: CNT_W] = v_active_q;
                rd_mux[0 +: CNT_W]  = h_active_q;
            end
            default: rd_mux = '0;
        endcase
        rdata_d = bus.reg_rd ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q         <= 1'b0;
            dv_q         <= 1'b0;
            first_vs_q   <= 1'b0;
            h_cnt_q      <= '0;
            h_line_q     <= '0;
            v_cnt_q      <= '0;
            h_active_q   <= '0;
            v_active_q   <= '0;
            frame_q      <= '0;
            sh_bypass_q  <= 1'b0;
            sh_mode_q    <= MODE_RST;
            sh_thresh_q  <= THRESH_RST;
            cfg_bypass_q <= 1'b0;
            cfg_mode_q   <= MODE_RST;
            cfg_thresh_q <= THRESH_RST;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            vs_q         <= vs_i;
            dv_q         <= dv_i;
            first_vs_q   <= first_vs_d;
            h_cnt_q      <= h_cnt_d;
            h_line_q     <= h_line_d;
            v_cnt_q      <= v_cnt_d;
            h_active_q   <= h_active_d;
            v_active_q   <= v_active_d;
            frame_q      <= frame_d;
            sh_bypass_q  <= sh_bypass_d;
            sh_mode_q    <= sh_mode_d;
            sh_thresh_q  <= sh_thresh_d;
            cfg_bypass_q <= cfg_bypass_d;
            cfg_mode_q   <= cfg_mode_d;
            cfg_thresh_q <= cfg_thresh_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= bus.reg_rd;
        end
    end

    assign cfg_bypass     = cfg_bypass_q;
    assign cfg_mode       = cfg_mode_q;
    assign cfg_thresh     = cfg_thresh_q;
    assign frame_cnt      = frame_q;
    assign bus.reg_rdata  = rdata_q;
    assign bus.reg_rvalid = rvalid_q;

endmodule

// File: tb/tb_sobel_cfg_ctrl.sv
// Directed bench for sobel_cfg_ctrl: register port, vsync commit, measurement and lock.
module tb_sobel_cfg_ctrl;

    logic        clk;
    logic        rst;
    logic        dv_i, hs_i, vs_i;
    logic        cfg_bypass;
    logic [2:0]  cfg_mode;
    logic [7:0]  cfg_thresh;
    logic [15:0] frame_cnt;
    logic        locked;

    int n_assert = 0;
    int n_fail   = 0;

    sobel_cfg_ctrl_if bus ();

    sobel_cfg_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .dv_i       (dv_i),
        .hs_i       (hs_i),
        .vs_i       (vs_i),
        .cfg_bypass (cfg_bypass),
        .cfg_mode   (cfg_mode),
        .cfg_thresh (cfg_thresh),
        .frame_cnt  (frame_cnt),
        .locked     (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic reg_write(input logic [2:0] addr, input logic [31:0] data);
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = addr;
        bus.reg_wdata = data;
        tick();
        bus.reg_wr    = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        check({tag, "_rv_idle"}, {31'd0, bus.reg_rvalid}, 32'd0);
        bus.reg_rd   = 1'b1;
        bus.reg_addr = addr;
        tick();
        bus.reg_rd   = 1'b0;
        check({tag, "_rv"}, {31'd0, bus.reg_rvalid}, 32'd1);
        check(tag, bus.reg_rdata, exp);
        tick();
    endtask

    task automatic video_line(input int w);
        dv_i = 1'b1;
        repeat (w) tick();
        dv_i = 1'b0;
        tick();
        hs_i = 1'b1;
        tick();
        hs_i = 1'b0;
        tick();
    endtask

    task automatic video_frame(input int w, input int h);
        repeat (h) video_line(w);
    endtask

    task automatic vs_pulse();
        vs_i = 1'b1;
        tick();
        vs_i = 1'b0;
        tick();
    endtask

    task automatic check_cfg(input string tag, input logic b, input logic [2:0] m,
                             input logic [7:0] t);
        check({tag, "_bypass"}, {31'd0, cfg_bypass}, {31'd0, b});
        check({tag, "_mode"}, {29'd0, cfg_mode}, {29'd0, m});
        check({tag, "_thresh"}, {24'd0, cfg_thresh}, {24'd0, t});
    endtask

    initial begin
        rst           = 1'b1;
        dv_i          = 1'b0;
        hs_i          = 1'b0;
        vs_i          = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.reg_rd    = 1'b0;
        bus.reg_addr  = 3'd0;
        bus.reg_wdata = 32'd0;

        // Reset state and register map
        do_reset();
        check("rst_rdata", bus.reg_rdata, 32'd0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check_cfg("rst_cfg", 1'b0, 3'd0, 8'd64);
        reg_read(3'd0, 32'h0000_0000, "rd_ctrl");
        reg_read(3'd1, 32'h0000_0040, "rd_thresh");
        check("rdata_hold", bus.reg_rdata, 32'h0000_0040);
        reg_read(3'd2, 32'h0000_0000, "rd_status");
        reg_read(3'd3, 32'h0000_0000, "rd_frame");
        reg_read(3'd4, 32'h0000_0000, "rd_res");
        reg_read(3'd5, 32'h0000_0000, "rd_unused");
        reg_write(3'd3, 32'h0000_FFFF);
        reg_read(3'd3, 32'h0000_0000, "rd_frame_ro");

        // Read and write to the same address: read sees the old value
        bus.reg_rd    = 1'b1;
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = 3'd1;
        bus.reg_wdata = 32'h0000_0077;
        tick();
        bus.reg_rd    = 1'b0;
        bus.reg_wr    = 1'b0;
        check("rw_same_old", bus.reg_rdata, 32'h0000_0040);
        tick();
        reg_read(3'd1, 32'h0000_0077, "rw_same_new");

        // Mid-frame commit applies only at vsync
        video_line(16);
        reg_write(3'd1, 32'h0000_0020);
        reg_write(3'd0, 32'h0000_010B);
        video_line(16);
        check_cfg("pend_cfg", 1'b0, 3'd0, 8'd64);
        reg_read(3'd2, 32'h0000_0002, "pend_status");
        reg_read(3'd0, 32'h0000_000B, "pend_ctrl_rd");
        vs_pulse();
        check_cfg("commit_cfg", 1'b1, 3'd5, 8'h20);
        reg_read(3'd2, 32'h0000_0000, "commit_status");

        // Resolution measurement and lock, starting mid-frame
        do_reset();
        video_frame(64, 5);
        vs_pulse();
        check("f1_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        reg_read(3'd4, 32'h0000_0000, "f1_res");
        video_frame(64, 48);
        vs_pulse();
        reg_read(3'd4, 32'h0030_0040, "f2_res");
        check("f2_locked", {31'd0, locked}, 32'd0);
        video_frame(64, 48);
        vs_pulse();
        check("f3_locked", {31'd0, locked}, 32'd1);
        check("f3_frame_cnt", {16'd0, frame_cnt}, 32'd3);
        reg_read(3'd3, 32'h0000_0003, "f3_frame_rd");
        reg_read(3'd2, 32'h0000_0001, "f3_status");

        // Resolution change drops lock, relocks after a second matching frame
        video_frame(32, 24);
        vs_pulse();
        check("chg_locked", {31'd0, locked}, 32'd0);
        reg_read(3'd4, 32'h0018_0020, "chg_res");
        video_frame(32, 24);
        vs_pulse();
        check("relock", {31'd0, locked}, 32'd1);

        // Commit write coinciding with vsync rise waits for the next one
        reg_write(3'd1, 32'h0000_0055);
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = 3'd0;
        bus.reg_wdata = 32'h0000_0104;
        vs_i          = 1'b1;
        tick();
        bus.reg_wr    = 1'b0;
        vs_i          = 1'b0;
        tick();
        check_cfg("same_edge_cfg", 1'b0, 3'd0, 8'd64);
        reg_read(3'd2, 32'h0000_0002, "same_edge_status");
        vs_pulse();
        check_cfg("next_edge_cfg", 1'b0, 3'd2, 8'h55);

        // Reset while a commit is pending
        reg_write(3'd1, 32'h0000_0011);
        reg_write(3'd0, 32'h0000_010B);
        video_line(16);
        reg_read(3'd2, 32'h0000_0002, "pre_rst_status");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cfg("mid_rst_cfg", 1'b0, 3'd0, 8'd64);
        check("mid_rst_locked", {31'd0, locked}, 32'd0);
        check("mid_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        reg_read(3'd2, 32'h0000_0000, "mid_rst_status");
        reg_read(3'd1, 32'h0000_0040, "mid_rst_thresh");
        video_line(16);
        video_line(16);
        vs_pulse();
        reg_read(3'd4, 32'h0000_0000, "post_rst_res");
        check_cfg("post_rst_cfg", 1'b0, 3'd0, 8'd64);
        check("post_rst_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_cfg_ctrl.md
Name: sobel_cfg_ctrl

Overview:
Register-mapped configuration and frame-sequencing controller for the Sobel video pipeline, clocked by the recovered pixel clock.
- Holds shadow copies of the pipeline settings: bypass, mode, threshold.
- Transfers them to the active outputs only at a vertical-sync boundary, so a frame is never processed with mixed settings.
- Measures incoming active resolution, counts frames, reports lock status through a simple register read/write port.

Parameters:
THRESH_RST, 8'd64, reset value of shadow and active threshold
MODE_RST, 3'd0, reset value of shadow and active mode
CNT_W, 12, width of horizontal/vertical resolution counters

Ports:
clk  in  1  pixel clock, the only clock
rst  in  1  synchronous reset, active-high
reg_wr  in  1  write strobe, one cycle
reg_rd  in  1  read strobe, one cycle
reg_addr  in  3  register word address
reg_wdata  in  32  write data
reg_rdata  out  32  read data, valid when reg_rvalid=1
reg_rvalid  out  1  one-cycle read-response pulse
dv_i  in  1  input data valid (active video)
hs_i  in  1  input hsync, active-high
vs_i  in  1  input vsync, active-high
cfg_bypass  out  1  active bypass setting
cfg_mode  out  3  active mode setting
cfg_thresh  out  8  active threshold setting
frame_cnt  out  16  frames seen since reset, wraps
locked  out  1  resolution stable for two consecutive frames

Behaviour:
Reset outputs and state:
- cfg_bypass=0, cfg_mode=MODE_RST, cfg_thresh=THRESH_RST; shadows equal these values.
- reg_rdata=0, reg_rvalid=0, frame_cnt=0, locked=0.
- Commit FSM=IDLE, lock FSM=UNLOCKED, first_vs=0, all counters 0.

Register map (word address):
- 0 CTRL, RW: bit0 bypass, bits3:1 mode, bit8 commit (write-1 only, reads 0).
- 1 THRESH, RW: bits7:0.
- 2 STATUS, RO: bit0 locked, bit1 commit pending.
- 3 FRAME, RO: bits15:0 frame_cnt.
- 4 RES, RO: bits27:16 v_active, bits11:0 h_active.
- 5-7: read as 0. Writes to RO or unused addresses are ignored.
- RW registers read back their shadow values, not the active values.

Register port rules:
- Write takes effect at the end of the strobe cycle.
- Read: reg_rdata and reg_rvalid are registered, so data appears one cycle after reg_rd; reg_rvalid is high for exactly one cycle; reg_rdata holds its value afterwards.
- Read and write in the same cycle to the same address: read returns the pre-write value.

Vsync edge detect:
- vs_q is vs_i registered; vs_rise = vs_i & ~vs_q.

Commit FSM:
- IDLE -> PENDING on a write to CTRL with bit8=1.
- PENDING -> IDLE on vs_rise. cfg_* take the shadow values at the end of that cycle and are visible on the next cycle.
- Shadow writes while PENDING are allowed; the values present on the vs_rise cycle are applied.
- Commit write and vs_rise in the same cycle: the FSM is IDLE so nothing is applied; state becomes PENDING and applies at the next vs_rise.
- Repeated commit writes while PENDING: no effect.
- cfg_* never change except on a PENDING vs_rise or on reset.

Measurement:
- h_cnt: +1 per cycle with dv_i=1. On the dv_i falling edge, h_line <= h_cnt and h_cnt <= 0; v_cnt increments.
- On vs_rise:
  - frame_cnt +1, wrapping 0xFFFF -> 0.
  - If first_vs=1: h_active <= h_line, v_active <= v_cnt.
  - first_vs <= 1, v_cnt <= 0.
- The first frame after reset is partial, so its resolution is discarded. Counters saturate at all-ones.

Lock FSM (evaluated on vs_rise with first_vs=1):
- UNLOCKED -> CHECK when the new measurement is nonzero in both dimensions.
- CHECK -> LOCKED if the new measurement equals the previous one; otherwise stay in CHECK.
- LOCKED -> CHECK if the measurement differs or is zero.
- locked = (state == LOCKED).

Reset mid-frame: all state returns to its reset values; the partial frame that follows is discarded per the first_vs rule.

Test Plan:
1. Reset, then read addresses 0-4 -> 0x00000000, 0x00000040, 0x0, 0x0, 0x0; each reg_rvalid appears one cycle after reg_rd; cfg_thresh=64.
2. Write THRESH=0x20 and CTRL=0x10B (commit, mode=5, bypass=1) mid-frame -> cfg_* unchanged and STATUS bit1=1 until vs_rise; the cycle after vs_rise cfg_thresh=0x20, cfg_mode=5, cfg_bypass=1 and STATUS bit1=0.
3. Drive 3 frames of 640x480 (dv bursts of 640 cycles, 480 lines) starting mid-frame after reset -> RES reads 0x01E00280 after the second vs_rise; locked=1 after the third; frame_cnt=3.
4. Once locked, switch to a 320x240 frame -> locked=0 at that vs_rise; locked=1 after a second 320x240 frame.
5. Commit write on the same cycle as vs_rise -> no cfg_* change at that edge; cfg_* apply at the following vs_rise.
6. Assert rst during PENDING mid-frame -> cfg_* return to reset values, pending=0, locked=0, and the next vs_rise does not update RES.
